// File: rtl/mult_test_sequencer.sv
// Sequences operand RAM reads for a multiplier test and issues the matching result writes.
// Latency: the write for each read trails it by the captured latency L (1..MAX_LAT).
// Backpressure: none; one read per RUN cycle, aborted only by stop or loss of pll_lock.
module mult_test_sequencer #(
  parameter int ADDR_WIDTH = 9,
  parameter int MAX_LAT    = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           pll_lock,
  input  logic                           loop_mode,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic [ADDR_WIDTH:0]            num_vec,
  input  logic [$clog2(MAX_LAT+1)-1:0]   lat,
  output logic                           rd_en,
  output logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic                           wr_en,
  output logic [ADDR_WIDTH-1:0]          wr_addr,
  output logic                           busy,
  output logic                           done,
  output logic                           lock_err,
  output logic [CNT_WIDTH-1:0]           cycle_count
);

  localparam int LAT_W = $clog2(MAX_LAT+1);
  localparam int TAP_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [LAT_W-1:0] MAX_L = LAT_W'(MAX_LAT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   armed_q;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [ADDR_WIDTH:0]    num_q;
  logic [ADDR_WIDTH:0]    idx_q;
  logic                   loop_q;
  logic [TAP_W-1:0]       tap_q;
  logic [TAP_W-1:0]       tap_d;
  logic [TAP_W-1:0]       drain_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [LAT_W-1:0]       lat_eff;
  logic [ADDR_WIDTH:0]    dly_q [MAX_LAT];
  logic                   go;
  logic                   last;
  logic                   halt;

  // armed_q blocks the first edge after reset release, so start is honoured from the second edge on
  assign go   = (state_q == IDLE) && armed_q && start && !stop && pll_lock;
  assign last = (idx_q == num_q - (ADDR_WIDTH+1)'(1));
  assign halt = stop || !pll_lock;

  // Clamp the requested latency into 1..MAX_LAT and turn it into a delay-line tap index
  always_comb begin
    lat_eff = lat;
    if (lat == '0)
      lat_eff = LAT_W'(1);
    else if (lat > MAX_L)
      lat_eff = MAX_L;
    tap_d = TAP_W'(lat_eff - LAT_W'(1));
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = (num_vec == '0) ? DONE : RUN;
      RUN:     if (halt || (last && !loop_q)) state_d = DRAIN;
      DRAIN:   if (drain_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; writes come straight off the selected delay-line tap
  always_comb begin
    rd_en   = (state_q == RUN);
    busy    = (state_q == RUN) || (state_q == DRAIN);
    done    = (state_q == DONE);
    rd_addr = base_q + idx_q[ADDR_WIDTH-1:0];
    wr_en   = dly_q[tap_q][ADDR_WIDTH];
    wr_addr = dly_q[tap_q][ADDR_WIDTH-1:0];
  end

  // Run parameters, read index, drain counter, cycle counter and sticky lock error
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      armed_q  <= 1'b0;
      base_q   <= '0;
      num_q    <= '0;
      idx_q    <= '0;
      loop_q   <= 1'b0;
      tap_q    <= '0;
      drain_q  <= '0;
      cnt_q    <= '0;
      lock_err <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (go) begin
        base_q   <= base_addr;
        num_q    <= num_vec;
        loop_q   <= loop_mode;
        tap_q    <= tap_d;
        idx_q    <= '0;
        cnt_q    <= '0;
        lock_err <= 1'b0;
      end else if (state_q == RUN) begin
        idx_q   <= last ? '0 : idx_q + (ADDR_WIDTH+1)'(1);
        drain_q <= tap_q;
        if (!pll_lock)
          lock_err <= 1'b1;
        if (cnt_q != '1)
          cnt_q <= cnt_q + CNT_WIDTH'(1);
      end else if ((state_q == DRAIN) && (drain_q != '0)) begin
        drain_q <= drain_q - TAP_W'(1);
      end
    end
  end

  assign cycle_count = cnt_q;

  // Read-to-write delay line; flushed on run start so stale entries beyond an old tap never surface
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < MAX_LAT; k++)
        dly_q[k] <= '0;
    end else if (go) begin
      for (int k = 0; k < MAX_LAT; k++)
        dly_q[k] <= '0;
    end else begin
      dly_q[0] <= {rd_en, rd_addr};
      for (int k = 1; k < MAX_LAT; k++)
        dly_q[k] <= dly_q[k-1];
    end
  end

endmodule

// File: tb/tb_mult_test_sequencer.sv
// Directed bench for mult_test_sequencer: per-cycle traces compared with hand-derived schedules.
module tb_mult_test_sequencer;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start, stop, pll_lock, loop_mode;
  logic [8:0]  base_addr;
  logic [9:0]  num_vec;
  logic [5:0]  lat;
  logic        rd_en, wr_en, busy, done, lock_err;
  logic [8:0]  rd_addr, wr_addr;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  logic        tr_rd   [64];
  logic [8:0]  tr_ra   [64];
  logic        tr_wr   [64];
  logic [8:0]  tr_wa   [64];
  logic        tr_done [64];
  logic        tr_busy [64];
  logic        tr_lerr [64];
  logic [31:0] tr_cnt  [64];

  mult_test_sequencer #(.ADDR_WIDTH(9), .MAX_LAT(32), .CNT_WIDTH(32)) dut (
    .clock(clock), .resetn(resetn), .start(start), .stop(stop), .pll_lock(pll_lock),
    .loop_mode(loop_mode), .base_addr(base_addr), .num_vec(num_vec), .lat(lat),
    .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .busy(busy), .done(done), .lock_err(lock_err), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Pulse start, then record outputs at each falling edge; cycle 0 is the first cycle after the start edge
  task automatic capture(input int ncyc, input int stop_cyc, input int lock_cyc);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      tr_rd[k] = rd_en;   tr_ra[k] = rd_addr;
      tr_wr[k] = wr_en;   tr_wa[k] = wr_addr;
      tr_done[k] = done;  tr_busy[k] = busy;
      tr_lerr[k] = lock_err; tr_cnt[k] = cycle_count;
      stop = (k == stop_cyc);
      pll_lock = (k != lock_cyc);
      @(negedge clock);
    end
    stop = 1'b0;
    pll_lock = 1'b1;
  endtask

  task automatic test_reset();
    bit seen;
    resetn = 1'b0; start = 1'b0; stop = 1'b0; pll_lock = 1'b1; loop_mode = 1'b0;
    base_addr = 9'd5; num_vec = 10'd1; lat = 6'd1;
    repeat (3) @(negedge clock);
    checks++;
    if ({rd_en, wr_en, busy, done, lock_err} !== 5'b0 || rd_addr !== 9'd0 || wr_addr !== 9'd0 || cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got en/busy/done/err=%b rd=%0d wr=%0d cnt=%0d want all 0",
               {rd_en, wr_en, busy, done, lock_err}, rd_addr, wr_addr, cycle_count);
    end
    resetn = 1'b1;
    start = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_edge_start busy got %b want 0", busy);
    end
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || rd_en !== 1'b1 || rd_addr !== 9'd5) begin
      errors++;
      $display("FAIL reset_second_edge_start busy=%b rd_en=%b rd_addr=%0d want 1 1 5", busy, rd_en, rd_addr);
    end
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_first_run_done got no done within 10 cycles want done pulse");
    end
    @(negedge clock);
  endtask

  task automatic test_single_pass();
    logic er, ew;
    base_addr = 9'd10; num_vec = 10'd4; lat = 6'd3; loop_mode = 1'b0;
    capture(12, -1, -1);
    for (int k = 0; k < 12; k++) begin
      er = (k < 4);
      ew = (k >= 3 && k < 7);
      checks++;
      if (tr_rd[k] !== er || (er && tr_ra[k] !== 9'(10 + k))) begin
        errors++;
        $display("FAIL single_rd k=%0d got en=%b addr=%0d want en=%b addr=%0d", k, tr_rd[k], tr_ra[k], er, 10 + k);
      end
      checks++;
      if (tr_wr[k] !== ew || (ew && tr_wa[k] !== 9'(10 + k - 3))) begin
        errors++;
        $display("FAIL single_wr k=%0d got en=%b addr=%0d want en=%b addr=%0d", k, tr_wr[k], tr_wa[k], ew, 10 + k - 3);
      end
      checks++;
      if (tr_done[k] !== (k == 7) || tr_busy[k] !== (k < 7)) begin
        errors++;
        $display("FAIL single_done_busy k=%0d got done=%b busy=%b want done=%b busy=%b", k, tr_done[k], tr_busy[k], k == 7, k < 7);
      end
    end
    checks++;
    if (cycle_count !== 32'd4 || lock_err !== 1'b0) begin
      errors++;
      $display("FAIL single_count got cnt=%0d lock_err=%b want 4 0", cycle_count, lock_err);
    end
  endtask

  task automatic test_wrap();
    logic er, ew;
    base_addr = 9'd510; num_vec = 10'd4; lat = 6'd1; loop_mode = 1'b0;
    capture(8, -1, -1);
    for (int k = 0; k < 8; k++) begin
      er = (k < 4);
      ew = (k >= 1 && k < 5);
      checks++;
      if (tr_rd[k] !== er || (er && tr_ra[k] !== 9'((510 + k) % 512))) begin
        errors++;
        $display("FAIL wrap_rd k=%0d got en=%b addr=%0d want en=%b addr=%0d", k, tr_rd[k], tr_ra[k], er, (510 + k) % 512);
      end
      checks++;
      if (tr_wr[k] !== ew || (ew && tr_wa[k] !== 9'((509 + k) % 512))) begin
        errors++;
        $display("FAIL wrap_wr k=%0d got en=%b addr=%0d want en=%b addr=%0d", k, tr_wr[k], tr_wa[k], ew, (509 + k) % 512);
      end
      checks++;
      if (tr_done[k] !== (k == 5)) begin
        errors++;
        $display("FAIL wrap_done k=%0d got %b want %b", k, tr_done[k], k == 5);
      end
    end
  endtask

  task automatic test_loop_stop();
    logic er, ew;
    base_addr = 9'd0; num_vec = 10'd3; lat = 6'd2; loop_mode = 1'b1;
    capture(12, 6, -1);
    loop_mode = 1'b0;
    for (int k = 0; k < 12; k++) begin
      er = (k < 7);
      ew = (k >= 2 && k < 9);
      checks++;
      if (tr_rd[k] !== er || (er && tr_ra[k] !== 9'(k % 3))) begin
        errors++;
        $display("FAIL loop_rd k=%0d got en=%b addr=%0d want en=%b addr=%0d", k, tr_rd[k], tr_ra[k], er, k % 3);
      end
      checks++;
      if (tr_wr[k] !== ew || (ew && tr_wa[k] !== 9'((k + 1) % 3))) begin
        errors++;
        $display("FAIL loop_wr k=%0d got en=%b addr=%0d want en=%b addr=%0d", k, tr_wr[k], tr_wa[k], ew, (k + 1) % 3);
      end
      checks++;
      if (tr_done[k] !== (k == 9) || tr_busy[k] !== (k < 9)) begin
        errors++;
        $display("FAIL loop_done_busy k=%0d got done=%b busy=%b want done=%b busy=%b", k, tr_done[k], tr_busy[k], k == 9, k < 9);
      end
    end
    checks++;
    if (cycle_count !== 32'd7) begin
      errors++;
      $display("FAIL loop_count got %0d want 7", cycle_count);
    end
  endtask

  task automatic test_lock_loss();
    logic er, ew;
    base_addr = 9'd100; num_vec = 10'd8; lat = 6'd5; loop_mode = 1'b0;
    capture(10, -1, 1);
    for (int k = 0; k < 10; k++) begin
      er = (k < 2);
      ew = (k >= 5 && k < 7);
      checks++;
      if (tr_rd[k] !== er || (er && tr_ra[k] !== 9'(100 + k))) begin
        errors++;
        $display("FAIL lock_rd k=%0d got en=%b addr=%0d want en=%b addr=%0d", k, tr_rd[k], tr_ra[k], er, 100 + k);
      end
      checks++;
      if (tr_wr[k] !== ew || (ew && tr_wa[k] !== 9'(95 + k))) begin
        errors++;
        $display("FAIL lock_wr k=%0d got en=%b addr=%0d want en=%b addr=%0d", k, tr_wr[k], tr_wa[k], ew, 95 + k);
      end
      checks++;
      if (tr_done[k] !== (k == 7)) begin
        errors++;
        $display("FAIL lock_done k=%0d got %b want %b", k, tr_done[k], k == 7);
      end
    end
    checks++;
    if (lock_err !== 1'b1 || cycle_count !== 32'd2) begin
      errors++;
      $display("FAIL lock_err_set got err=%b cnt=%0d want 1 2", lock_err, cycle_count);
    end
    num_vec = 10'd1; lat = 6'd1;
    capture(4, -1, -1);
    checks++;
    if (tr_lerr[0] !== 1'b0 || tr_done[2] !== 1'b1) begin
      errors++;
      $display("FAIL lock_err_clear got err=%b done@2=%b want 0 1", tr_lerr[0], tr_done[2]);
    end
  endtask

  task automatic test_lat_clamp();
    logic ew;
    base_addr = 9'd20; num_vec = 10'd2; lat = 6'd0; loop_mode = 1'b0;
    capture(6, -1, -1);
    for (int k = 0; k < 6; k++) begin
      ew = (k >= 1 && k < 3);
      checks++;
      if (tr_wr[k] !== ew || (ew && tr_wa[k] !== 9'(19 + k)) || tr_done[k] !== (k == 3)) begin
        errors++;
        $display("FAIL lat0 k=%0d got wr=%b addr=%0d done=%b want wr=%b addr=%0d done=%b",
                 k, tr_wr[k], tr_wa[k], tr_done[k], ew, 19 + k, k == 3);
      end
    end
    base_addr = 9'd30; lat = 6'd37;
    capture(38, -1, -1);
    for (int k = 0; k < 38; k++) begin
      ew = (k >= 32 && k < 34);
      checks++;
      if (tr_wr[k] !== ew || (ew && tr_wa[k] !== 9'(k - 2)) || tr_done[k] !== (k == 34)) begin
        errors++;
        $display("FAIL latmax k=%0d got wr=%b addr=%0d done=%b want wr=%b addr=%0d done=%b",
                 k, tr_wr[k], tr_wa[k], tr_done[k], ew, k - 2, k == 34);
      end
    end
  endtask

  task automatic test_num_vec_zero();
    base_addr = 9'd40; num_vec = 10'd0; lat = 6'd4; loop_mode = 1'b0;
    capture(4, -1, -1);
    checks++;
    if (tr_done[0] !== 1'b1 || tr_cnt[0] !== 32'd0 || tr_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL nv0_done got done=%b cnt=%0d busy=%b want 1 0 0", tr_done[0], tr_cnt[0], tr_busy[0]);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (tr_rd[k] !== 1'b0 || tr_wr[k] !== 1'b0 || (k > 0 && tr_done[k] !== 1'b0)) begin
        errors++;
        $display("FAIL nv0_quiet k=%0d got rd=%b wr=%b done=%b want 0 0 %b", k, tr_rd[k], tr_wr[k], tr_done[k], k == 0);
      end
    end
  endtask

  task automatic test_start_stop_idle();
    base_addr = 9'd50; num_vec = 10'd3; lat = 6'd1;
    start = 1'b1; stop = 1'b1;
    @(negedge clock);
    start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL start_stop k=%0d got busy=%b rd=%b done=%b want 0 0 0", k, busy, rd_en, done);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset_mid_drain();
    base_addr = 9'd10; num_vec = 10'd4; lat = 6'd3; loop_mode = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (busy !== 1'b1 || rd_en !== 1'b0 || wr_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_drain_setup got busy=%b rd=%b wr=%b want 1 0 1", busy, rd_en, wr_en);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({rd_en, wr_en, busy, done, lock_err} !== 5'b0 || rd_addr !== 9'd0 || wr_addr !== 9'd0 || cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL mid_drain_reset got en/busy/done/err=%b rd=%0d wr=%0d cnt=%0d want all 0",
               {rd_en, wr_en, busy, done, lock_err}, rd_addr, wr_addr, cycle_count);
    end
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      checks++;
      if (wr_en !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_drain_after k=%0d got wr=%b busy=%b want 0 0", k, wr_en, busy);
      end
    end
    test_single_pass();
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_wrap();
    test_loop_stop();
    test_lock_loss();
    test_lat_clamp();
    test_num_vec_zero();
    test_start_stop_idle();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
